// File: rtl/uart_tx_fifo_if.sv
// Byte-write and transmitter-launch signals shared between the UART TX FIFO and its neighbours.
// The master side writes bytes and reports transmitter state; the slave side is the FIFO.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      wr_data;
  logic            wr_en;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic [1:0]      tx_state;
  logic [7:0]      data_out;
  logic            enable;

  modport master (
    output wr_data, wr_en, tx_state,
    input  full, empty, count, overflow, data_out, enable
  );

  modport slave (
    input  wr_data, wr_en, tx_state,
    output full, empty, count, overflow, data_out, enable
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding the UART transmitter: queues burst writes and launches
// one byte per frame with a single-cycle enable whenever the transmitter is idle.
module uart_tx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ZERO = '0;
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;
  logic              full_q;
  logic              empty_q;
  logic              overflow_q;
  logic              enable_q;
  logic [7:0]        data_q;
  logic              do_write;
  logic              launch;

  // Fullness is judged on the registered value, so a write on a pop cycle while full is still dropped.
  assign do_write = bus.wr_en && !full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A launch needs the transmitter idle; afterwards wait for it to leave and then return to IDLE.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty_q && (bus.tx_state == 2'd0)) begin
          launch     = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: state_next = S_BUSY;
      S_BUSY: begin
        if (bus.tx_state != 2'd0) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.tx_state == 2'd0) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    case ({do_write, launch})
      2'b10:   count_next = count + COUNT_ONE;
      2'b01:   count_next = count - COUNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Flags are registered from the next count so every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      enable_q   <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (launch) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        data_q <= mem[rd_ptr];
      end
      count      <= count_next;
      full_q     <= (count_next == COUNT_FULL);
      empty_q    <= (count_next == COUNT_ZERO);
      overflow_q <= bus.wr_en && full_q;
      enable_q   <= launch;
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count;
  assign bus.overflow = overflow_q;
  assign bus.enable   = enable_q;
  assign bus.data_out = data_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a stub transmitter with a short bit time, a queue-based
// reference model checked every cycle, a vector table and hand-written corner sequences.
module tb_uart_tx_fifo;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int BT     = 3;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic [4:0] exp_count;
    logic       exp_empty;
    logic       exp_enable;
    logic [7:0] exp_dout;
  } vec_t;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       chk_on = 1'b0;
  logic       hold   = 1'b0;
  logic [1:0] tx_st  = 2'd0;
  int         tick   = 0;
  int         nbit   = 0;
  int         n_vec  = 0;
  int         n_mis  = 0;
  logic [7:0] rx_q[$];

  logic [7:0] mq[$];
  int         m_phase = 0;
  int         m_pre   = 0;
  logic       m_go    = 1'b0;
  logic       m_en    = 1'b0;
  logic       m_ovf   = 1'b0;
  logic [7:0] m_dout  = 8'h00;

  vec_t       vecs[7];
  logic [7:0] wrap_bytes[$];
  int         pct = 10;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_fifo #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.tx_state = tx_st;

  always #5 clk = ~clk;

  // Stub transmitter: accepts a launch only in IDLE, then START, 8 DATA bits, STOP; hold pins it in DATA.
  always @(posedge clk) begin
    if (hold) begin
      tx_st <= 2'd2;
      tick  <= 0;
      nbit  <= 0;
    end else begin
      case (tx_st)
        2'd0: begin
          if (bus.enable) begin
            rx_q.push_back(bus.data_out);
            tx_st <= 2'd1;
            tick  <= 0;
          end
        end
        2'd1: begin
          if (tick == BT - 1) begin
            tx_st <= 2'd2;
            tick  <= 0;
            nbit  <= 0;
          end else begin
            tick <= tick + 1;
          end
        end
        2'd2: begin
          if (tick == BT - 1) begin
            tick <= 0;
            if (nbit == 7) tx_st <= 2'd3;
            else nbit <= nbit + 1;
          end else begin
            tick <= tick + 1;
          end
        end
        default: begin
          if (tick == BT - 1) tx_st <= 2'd0;
          else tick <= tick + 1;
        end
      endcase
    end
  end

  // Reference model: a byte queue plus "launch outstanding" bookkeeping driven by the transmitter state.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_phase = 0;
      m_en    = 1'b0;
      m_ovf   = 1'b0;
      m_dout  = 8'h00;
    end else begin
      m_pre = mq.size();
      m_go  = (m_phase == 0) && (m_pre > 0) && (tx_st == 2'd0);
      m_en  = m_go;
      m_ovf = bus.wr_en && (m_pre == DEPTH);
      if (m_go) m_dout = mq.pop_front();
      if (bus.wr_en && (m_pre != DEPTH)) mq.push_back(bus.wr_data);
      case (m_phase)
        0:       if (m_go) m_phase = 1;
        1:       m_phase = 2;
        2:       if (tx_st != 2'd0) m_phase = 3;
        default: if (tx_st == 2'd0) m_phase = 0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("model_count",    32'(bus.count),    32'(mq.size()));
      checkOutput("model_full",     32'(bus.full),     32'(mq.size() == DEPTH));
      checkOutput("model_empty",    32'(bus.empty),    32'(mq.size() == 0));
      checkOutput("model_overflow", 32'(bus.overflow), 32'(m_ovf));
      checkOutput("model_enable",   32'(bus.enable),   32'(m_en));
      checkOutput("model_data_out", 32'(bus.data_out), 32'(m_dout));
    end
  end

  task automatic applyStimulus(input logic we, input logic [7:0] data);
    @(negedge clk);
    bus.wr_en   = we;
    bus.wr_data = data;
  endtask

  task automatic checkResetState();
    checkOutput("rst_count",    32'(bus.count),    32'd0);
    checkOutput("rst_empty",    32'(bus.empty),    32'd1);
    checkOutput("rst_full",     32'(bus.full),     32'd0);
    checkOutput("rst_enable",   32'(bus.enable),   32'd0);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("rst_data_out", 32'(bus.data_out), 32'd0);
  endtask

  task automatic waitIdle(input int max_cycles);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      @(negedge clk);
      ok = bus.empty && (tx_st == 2'd0) && !bus.enable && !hold;
    end
    checkOutput("wait_idle", 32'(ok), 32'd1);
  endtask

  task automatic waitTx(input logic [1:0] val, input int max_cycles);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      @(negedge clk);
      ok = (tx_st == val);
    end
    checkOutput("wait_tx_state", 32'(ok), 32'd1);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetState();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    vecs[0] = '{1'b1, 8'hA5, 5'd1, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 5'd0, 1'b1, 1'b1, 8'hA5};
    vecs[2] = '{1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'hA5};
    vecs[3] = '{1'b1, 8'h3C, 5'd1, 1'b0, 1'b0, 8'hA5};
    vecs[4] = '{1'b1, 8'h5A, 5'd2, 1'b0, 1'b0, 8'hA5};
    vecs[5] = '{1'b1, 8'hC3, 5'd3, 1'b0, 1'b0, 8'hA5};
    vecs[6] = '{1'b0, 8'h00, 5'd3, 1'b0, 1'b0, 8'hA5};

    repeat (3) @(negedge clk);
    checkResetState();
    rst_n  = 1'b1;
    chk_on = 1'b1;

    $display("[TB] single byte latency and queueing behind a busy transmitter");
    rx_q.delete();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wr_en, vecs[i].wr_data);
      @(posedge clk);
      #1;
      checkOutput("vec_count",    32'(bus.count),    32'(vecs[i].exp_count));
      checkOutput("vec_empty",    32'(bus.empty),    32'(vecs[i].exp_empty));
      checkOutput("vec_full",     32'(bus.full),     32'd0);
      checkOutput("vec_enable",   32'(bus.enable),   32'(vecs[i].exp_enable));
      checkOutput("vec_data_out", 32'(bus.data_out), 32'(vecs[i].exp_dout));
    end

    $display("[TB] asynchronous reset mid-frame with three bytes queued");
    waitTx(2'd2, 50);
    #2 rst_n = 1'b0;
    #1 checkResetState();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h7E);
    applyStimulus(1'b0, 8'h00);
    for (int i = 0; i < 100 && tx_st != 2'd0; i++) begin
      checkOutput("no_launch_while_busy", 32'(bus.enable), 32'd0);
      @(negedge clk);
    end
    checkOutput("tx_returned_idle", 32'(tx_st), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("relaunch_enable", 32'(bus.enable),   32'd1);
    checkOutput("relaunch_data",   32'(bus.data_out), 32'h7E);
    waitIdle(200);
    checkOutput("reset_rx_size", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      checkOutput("reset_rx_0", 32'(rx_q[0]), 32'hA5);
      checkOutput("reset_rx_1", 32'(rx_q[1]), 32'h7E);
    end

    $display("[TB] burst of sixteen bytes");
    rx_q.delete();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i));
    applyStimulus(1'b0, 8'h00);
    waitIdle(2000);
    checkOutput("burst_rx_size", 32'(rx_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      checkOutput("burst_rx_byte", 32'(rx_q[i]), 32'(i));
    end

    $display("[TB] overflow with the transmitter held busy");
    hold = 1'b1;
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h40 + i));
    @(posedge clk);
    #1;
    checkOutput("ovf_full_16",  32'(bus.full),     32'd1);
    checkOutput("ovf_count_16", 32'(bus.count),    32'd16);
    checkOutput("ovf_pre",      32'(bus.overflow), 32'd0);
    applyStimulus(1'b1, 8'hFF);
    @(posedge clk);
    #1;
    checkOutput("ovf_pulse",    32'(bus.overflow), 32'd1);
    checkOutput("ovf_count_17", 32'(bus.count),    32'd16);
    applyStimulus(1'b0, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("ovf_one_cycle", 32'(bus.overflow), 32'd0);
    rx_q.delete();
    hold = 1'b0;
    waitIdle(2000);
    checkOutput("ovf_rx_size", 32'(rx_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      checkOutput("ovf_rx_byte", 32'(rx_q[i]), 32'(8'h40 + i));
    end

    $display("[TB] simultaneous write and pop across the pointer wrap");
    pulseReset();
    hold = 1'b1;
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 8'(8'h80 + i));
    applyStimulus(1'b0, 8'h00);
    hold = 1'b0;
    waitIdle(2000);
    hold = 1'b1;
    wrap_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hD0};
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, wrap_bytes[i]);
    applyStimulus(1'b0, 8'h00);
    rx_q.delete();
    hold = 1'b0;
    waitTx(2'd0, 200);
    bus.wr_en   = 1'b1;
    bus.wr_data = wrap_bytes[5];
    @(posedge clk);
    #1;
    checkOutput("wrap_count",  32'(bus.count),    32'd5);
    checkOutput("wrap_enable", 32'(bus.enable),   32'd1);
    checkOutput("wrap_data",   32'(bus.data_out), 32'h11);
    applyStimulus(1'b0, 8'h00);
    waitIdle(2000);
    checkOutput("wrap_rx_size", 32'(rx_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checkOutput("wrap_rx_byte", 32'(rx_q[i]), 32'(wrap_bytes[i]));
    end

    $display("[TB] randomized traffic against the reference model");
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 5;
          1:       pct = 25;
          default: pct = 70;
        endcase
      end
      applyStimulus(($urandom_range(0, 99) < pct), 8'($urandom));
      if ($urandom_range(0, 199) == 0) hold = ~hold;
    end
    hold = 1'b0;
    applyStimulus(1'b0, 8'h00);
    waitIdle(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
